// File: rtl/seq_logic_unit_if.sv
// Bundles the operand and result handshake signals of seq_logic_unit.
// The master drives operands and the consumer ready; the slave returns results.
// W is fixed at 2*N so that both sides agree on the data width.
interface seq_logic_unit_if #(
    parameter int N  = 2,
    parameter int CW = 16
);
    localparam int W = 2 * N;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    f;
    logic          acc_sel;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic          zero;
    logic          parity;
    logic [W-1:0]  acc;
    logic [CW-1:0] count;

    modport master (
        output in_valid, a, b, f, acc_sel, acc_clr, out_ready,
        input  in_ready, out_valid, y, zero, parity, acc, count
    );

    modport slave (
        input  in_valid, a, b, f, acc_sel, acc_clr, out_ready,
        output in_ready, out_valid, y, zero, parity, acc, count
    );
endinterface

// File: rtl/seq_logic_unit.sv
// Two-stage bitwise logic unit with an accumulator and a completed-result counter.
// Latency: 2 cycles from accept to valid result; 1 beat/cycle with out_ready high.
// Backpressure: S2 holds while out_ready is low; S1 then fills and in_ready drops.
module seq_logic_unit #(
    parameter int N  = 2,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_logic_unit_if.slave    bus
);
    localparam int W = 2 * N;

    // Stage 1: captured operands
    logic          s1_valid;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    logic [2:0]    s1_f;
    logic          s1_acc_sel;

    // Stage 2: registered result and flags
    logic          out_valid_q;
    logic [W-1:0]  y_q;
    logic          zero_q;
    logic          parity_q;

    logic [W-1:0]  acc_q;
    logic [CW-1:0] count_q;

    logic          adv;
    logic          accept;
    logic          out_hs;
    logic [W-1:0]  opb;
    logic [W-1:0]  res;

    // S1 may move into S2 whenever S2 is empty or being drained this cycle
    assign adv    = s1_valid && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign out_hs = out_valid_q && bus.out_ready;

    assign bus.in_ready  = !s1_valid || adv;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.acc       = acc_q;
    assign bus.count     = count_q;

    // Logic function of the S1 beat; the accumulator is read live, so a beat
    // that follows an accumulating beat sees its write-back without a stall
    always_comb begin
        opb = s1_acc_sel ? acc_q : s1_b;
        res = '0;
        case (s1_f)
            3'b000:  res = s1_a & opb;
            3'b001:  res = s1_a | opb;
            3'b010:  res = s1_a ^ opb;
            3'b011:  res = ~(s1_a | opb);
            3'b100:  res = ~(s1_a & opb);
            3'b101:  res = ~(s1_a ^ opb);
            3'b110:  res = s1_a;
            3'b111:  res = ~s1_a;
            default: res = '0;
        endcase
    end

    // S1 register: refill on accept (even while advancing), empty on advance alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_f       <= '0;
            s1_acc_sel <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_a       <= bus.a;
            s1_b       <= bus.b;
            s1_f       <= bus.f;
            s1_acc_sel <= bus.acc_sel;
        end else if (adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // S2 register: load on advance, clear valid on a drain with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
        end else if (adv) begin
            out_valid_q <= 1'b1;
            y_q         <= res;
            zero_q      <= (res == '0);
            parity_q    <= ^res;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator: clear wins over a same-cycle write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end else if (adv && s1_acc_sel) begin
            acc_q <= res;
        end
    end

    // Completed-handshake counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (out_hs) begin
            count_q <= count_q + 1'b1;
        end
    end

    // An unknown function code on a live S1 beat yields an undefined result
    assert property (@(posedge clk) disable iff (!rst_n) s1_valid |-> !$isunknown(s1_f))
        else $error("seq_logic_unit: unknown function code in S1");

endmodule
